frl_ckpt_ctrl: RTL and testbench
================================

FRL_CKPT_CTRL -- requirements
Module: frl_ckpt_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CKPT, default 4, number of branch checkpoints (power of 2).
REQ-002 The block SHALL have parameter PID_W, default 7, physical register ID width.
REQ-003 The block SHALL have parameter PTR_W, default 8, free-list FIFO pointer width ((n+1)-bit).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high. Ports:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous active-high reset
 alloc_req  in  1  dispatch requests one free PID
 alloc_grant  out  1  PID granted this cycle
 alloc_pid  out  PID_W  granted PID (valid with alloc_grant)
 free_req  in  1  commit returns a PID
 free_pid  in  PID_W  returned PID
 ckpt_req  in  1  dispatching branch requests a checkpoint
 ckpt_ack  out  1  checkpoint taken this cycle
 ckpt_tag  out  $clog2(NUM_CKPT)  tag of taken checkpoint
 ckpt_full  out  1  no free checkpoint slot
 br_valid  in  1  branch resolution strobe
 br_tag  in  $clog2(NUM_CKPT)  resolved branch tag
 br_mispred  in  1  resolution is a misprediction
 flush  out  1  squash pulse to dispatch/RS
 flush_mask  out  NUM_CKPT  tags squashed by this flush
 ckpt_err  out  1  resolution on invalid tag
 fifo_r_en  out  1  free-list pop
 fifo_dout  in  PID_W  free-list head
 fifo_r_ptr  in  PTR_W  free-list read pointer
 fifo_empty  in  1  free-list empty
 fifo_w_en  out  1  free-list push
 fifo_din  out  PID_W  pushed PID
 fifo_full  in  1  free-list full
 fifo_chg_r_en  out  1  read-pointer restore enable
 fifo_chg_r_val  out  PTR_W  restored read pointer

Function
REQ-005 FSM states IDLE, FLUSH; IDLE->FLUSH on br_valid&br_mispred&valid[br_tag]; FLUSH->IDLE unconditionally after one cycle.
REQ-006 alloc_grant SHALL equal alloc_req & !fifo_empty & state==IDLE & !(mispredict this cycle); fifo_r_en = alloc_grant; alloc_pid = fifo_dout (zero latency).
REQ-007 fifo_w_en SHALL equal free_req & !fifo_full in every state, including FLUSH and mispredict cycles; fifo_din = free_pid.
REQ-008 Per slot the block SHALL hold valid bit, saved pointer (PTR_W) and older-mask (NUM_CKPT bits, bit s set = slot s older).
REQ-009 ckpt_ack SHALL equal ckpt_req & !ckpt_full & state==IDLE & !(mispredict this cycle); ckpt_tag = lowest-index slot invalid at start of cycle.
REQ-010 On ckpt_ack the slot SHALL store pointer fifo_r_ptr + alloc_grant (mod 2^PTR_W) and older-mask = current valid vector; valid set.
REQ-011 ckpt_full SHALL be 1 iff all valid bits are set at start of cycle; a slot freed this cycle is not reusable until next cycle.
REQ-012 Correct resolve (br_valid & !br_mispred & valid[br_tag]): clear valid[br_tag] and clear bit br_tag in every older-mask.
REQ-013 Mispredict on valid tag t: fifo_chg_r_en=1, fifo_chg_r_val=ptr[t] same cycle (combinational); clear valid[t] and valid[s] for every s with older-mask[s][t]=1.
REQ-014 flush and flush_mask SHALL be registered: asserted for exactly the FLUSH cycle, flush_mask = t plus all younger slots squashed.
REQ-015 br_valid with valid[br_tag]=0 SHALL be ignored except ckpt_err pulses high for that cycle.
REQ-016 Surviving older checkpoints SHALL keep saved pointers unchanged across a flush.

Reset
REQ-017 On reset all valid bits and older-masks SHALL clear, FSM to IDLE; flush, flush_mask, ckpt_err registered outputs 0.
REQ-018 During reset all combinational outputs (alloc_grant, fifo_r_en, fifo_w_en, ckpt_ack, fifo_chg_r_en) SHALL be 0; reset mid-flush aborts the flush.

Structure
REQ-019 NUM_CKPT, PID_W, PTR_W defaults and the FSM state encoding SHALL live in the shared processor package.
REQ-020 Lowest-free-slot selection SHALL be a sub-module named ckpt_prio_enc; the free-list FIFO stays external.

Verification
REQ-021 After reset with FIFO full (r_ptr=0), alloc_req 3 cycles -> PIDs 0,1,2 granted, r_ptr=3.
REQ-022 ckpt_req + alloc_req same cycle at r_ptr=3 -> ckpt_tag=0, saved ptr=4.
REQ-023 Tags 0,1,2 taken in order; mispredict tag 1 -> fifo_chg_r_val=ptr[1], next-cycle flush=1, flush_mask=4'b0110, tag 0 still valid.
REQ-024 4 checkpoints valid -> ckpt_full=1, ckpt_ack=0; correct resolve tag 2 -> next ckpt_req gets tag 2.
REQ-025 free_req PID 0x45 during mispredict cycle -> fifo_w_en=1, alloc_grant=0; br_valid on invalid tag 3 -> ckpt_err=1, no state change.

Source files
------------

// File: rtl/frl_ckpt_pkg.sv
// Shared processor package for the free-list checkpoint controller:
// default geometry and the controller FSM state encoding.
package frl_ckpt_pkg;

  localparam int unsigned FRL_NUM_CKPT = 4;
  localparam int unsigned FRL_PID_W    = 7;
  localparam int unsigned FRL_PTR_W    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } ckpt_state_e;

endpackage

// File: rtl/frl_ckpt_ctrl_prio.sv
// Lowest-index priority encoder used to pick the next free checkpoint slot.
module ckpt_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frl_ckpt_ctrl.sv
// Branch checkpoint controller for a free-list rename scheme: snapshots the
// free-list read pointer per branch and restores it on a misprediction.
module frl_ckpt_ctrl
  import frl_ckpt_pkg::*;
#(
  parameter int unsigned NUM_CKPT = FRL_NUM_CKPT,
  parameter int unsigned PID_W    = FRL_PID_W,
  parameter int unsigned PTR_W    = FRL_PTR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alloc_req,
  output logic                        alloc_grant,
  output logic [PID_W-1:0]            alloc_pid,
  input  logic                        free_req,
  input  logic [PID_W-1:0]            free_pid,
  input  logic                        ckpt_req,
  output logic                        ckpt_ack,
  output logic [$clog2(NUM_CKPT)-1:0] ckpt_tag,
  output logic                        ckpt_full,
  input  logic                        br_valid,
  input  logic [$clog2(NUM_CKPT)-1:0] br_tag,
  input  logic                        br_mispred,
  output logic                        flush,
  output logic [NUM_CKPT-1:0]         flush_mask,
  output logic                        ckpt_err,
  output logic                        fifo_r_en,
  input  logic [PID_W-1:0]            fifo_dout,
  input  logic [PTR_W-1:0]            fifo_r_ptr,
  input  logic                        fifo_empty,
  output logic                        fifo_w_en,
  output logic [PID_W-1:0]            fifo_din,
  input  logic                        fifo_full,
  output logic                        fifo_chg_r_en,
  output logic [PTR_W-1:0]            fifo_chg_r_val
);

  localparam int unsigned TAG_W = $clog2(NUM_CKPT);

  ckpt_state_e state_q, state_d;

  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] older_d [NUM_CKPT];
  logic [PTR_W-1:0]    ptr_q   [NUM_CKPT];

  logic                flush_q, ckpt_err_q;
  logic [NUM_CKPT-1:0] flush_mask_q;

  logic                idle, tag_valid, mispredict, resolve_ok, bad_tag;
  logic                slot_free;
  logic [TAG_W-1:0]    free_tag;
  logic [NUM_CKPT-1:0] kill;

  ckpt_prio_enc #(.N(NUM_CKPT), .W(TAG_W)) u_prio (
    .req   (~valid_q),
    .idx   (free_tag),
    .found (slot_free)
  );

  always_comb begin
    idle      = (state_q == ST_IDLE);
    tag_valid = valid_q[br_tag];
    // Mispredicts are only taken in IDLE; the FLUSH cycle is already squashing.
    mispredict = !reset && idle && br_valid && br_mispred && tag_valid;
    resolve_ok = !reset && br_valid && !br_mispred && tag_valid;
    bad_tag    = !reset && br_valid && !tag_valid;

    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      kill[s] = (TAG_W'(s) == br_tag) || older_q[s][br_tag];
    end

    ckpt_full   = !slot_free;
    ckpt_tag    = free_tag;
    ckpt_ack    = !reset && ckpt_req && slot_free && idle && !mispredict;
    alloc_grant = !reset && alloc_req && !fifo_empty && idle && !mispredict;
    alloc_pid   = fifo_dout;
    fifo_r_en   = alloc_grant;

    fifo_w_en = !reset && free_req && !fifo_full;
    fifo_din  = free_pid;

    fifo_chg_r_en  = mispredict;
    fifo_chg_r_val = ptr_q[br_tag];

    flush      = flush_q;
    flush_mask = flush_mask_q;
    ckpt_err   = ckpt_err_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      older_d[s] = older_q[s];
    end
    // New slot's older-mask is taken before the resolving tag is stripped,
    // so a same-cycle correct resolve also clears it from the new mask.
    if (ckpt_ack) begin
      valid_d[free_tag] = 1'b1;
      older_d[free_tag] = valid_q;
    end
    if (resolve_ok) begin
      valid_d[br_tag] = 1'b0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        older_d[s][br_tag] = 1'b0;
      end
    end
    if (mispredict) begin
      valid_d = valid_q & ~kill;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        if (kill[s]) older_d[s] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      valid_q      <= '0;
      flush_q      <= 1'b0;
      flush_mask_q <= '0;
      ckpt_err_q   <= 1'b0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        older_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_q      <= mispredict;
      flush_mask_q <= mispredict ? kill : '0;
      ckpt_err_q   <= bad_tag;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        older_q[s] <= older_d[s];
      end
      if (ckpt_ack) ptr_q[free_tag] <= fifo_r_ptr + PTR_W'(alloc_grant);
    end
  end

endmodule

// File: tb/tb_frl_ckpt_ctrl.sv
// Directed bench for frl_ckpt_ctrl with a small behavioural free-list FIFO.
module tb_frl_ckpt_ctrl;

  localparam int unsigned NUM_CKPT = 4;
  localparam int unsigned PID_W    = 7;
  localparam int unsigned PTR_W    = 8;

  logic clk = 1'b0;
  logic reset;
  logic alloc_req, alloc_grant;
  logic [PID_W-1:0] alloc_pid;
  logic free_req;
  logic [PID_W-1:0] free_pid;
  logic ckpt_req, ckpt_ack, ckpt_full;
  logic [1:0] ckpt_tag;
  logic br_valid, br_mispred;
  logic [1:0] br_tag;
  logic flush, ckpt_err;
  logic [NUM_CKPT-1:0] flush_mask;
  logic fifo_r_en, fifo_w_en, fifo_chg_r_en;
  logic [PID_W-1:0] fifo_dout, fifo_din;
  logic [PTR_W-1:0] fifo_r_ptr, fifo_chg_r_val;
  logic fifo_empty, fifo_full;

  logic [PTR_W-1:0] r_ptr, w_ptr;
  logic [PID_W-1:0] mem [128];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frl_ckpt_ctrl #(.NUM_CKPT(NUM_CKPT), .PID_W(PID_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_pid(alloc_pid),
    .free_req(free_req), .free_pid(free_pid),
    .ckpt_req(ckpt_req), .ckpt_ack(ckpt_ack), .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full),
    .br_valid(br_valid), .br_tag(br_tag), .br_mispred(br_mispred),
    .flush(flush), .flush_mask(flush_mask), .ckpt_err(ckpt_err),
    .fifo_r_en(fifo_r_en), .fifo_dout(fifo_dout), .fifo_r_ptr(fifo_r_ptr),
    .fifo_empty(fifo_empty), .fifo_w_en(fifo_w_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_chg_r_en(fifo_chg_r_en), .fifo_chg_r_val(fifo_chg_r_val)
  );

  // External free list: full of PIDs 0..127 after reset.
  assign fifo_r_ptr = r_ptr;
  assign fifo_dout  = mem[r_ptr[6:0]];
  assign fifo_empty = (r_ptr == w_ptr);
  assign fifo_full  = ((r_ptr ^ w_ptr) == 8'h80);

  always @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      w_ptr <= 8'h80;
      for (int i = 0; i < 128; i++) mem[i] <= PID_W'(i);
    end else begin
      if (fifo_chg_r_en) r_ptr <= fifo_chg_r_val;
      else if (fifo_r_en) r_ptr <= r_ptr + 8'd1;
      if (fifo_w_en) begin
        mem[w_ptr[6:0]] <= fifo_din;
        w_ptr <= w_ptr + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    alloc_req = 0; free_req = 0; free_pid = '0; ckpt_req = 0;
    br_valid = 0; br_tag = '0; br_mispred = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    reset = 1;
    alloc_req = 1; ckpt_req = 1; free_req = 1; free_pid = 7'h11;
    br_valid = 1; br_mispred = 1;
    @(posedge clk); #1;
    #1;
    check("rst_alloc_grant", 32'(alloc_grant), 0);
    check("rst_ckpt_ack", 32'(ckpt_ack), 0);
    check("rst_fifo_w_en", 32'(fifo_w_en), 0);
    check("rst_chg_en", 32'(fifo_chg_r_en), 0);
    @(posedge clk); #1;
    clr();
    reset = 0;
    #1;
    check("rst_flush", 32'(flush), 0);
    check("rst_flush_mask", 32'(flush_mask), 0);
    check("rst_ckpt_err", 32'(ckpt_err), 0);
    check("rst_ckpt_full", 32'(ckpt_full), 0);

    for (int i = 0; i < 3; i++) begin
      alloc_req = 1; #1;
      check("alloc_grant", 32'(alloc_grant), 1);
      check("alloc_pid", 32'(alloc_pid), 32'(i));
      step();
    end
    check("r_ptr_after_3", 32'(r_ptr), 3);

    alloc_req = 1; ckpt_req = 1; #1;
    check("ck0_ack", 32'(ckpt_ack), 1);
    check("ck0_tag", 32'(ckpt_tag), 0);
    check("ck0_pid", 32'(alloc_pid), 3);
    step();
    alloc_req = 1; ckpt_req = 1; #1;
    check("ck1_tag", 32'(ckpt_tag), 1);
    check("ck1_pid", 32'(alloc_pid), 4);
    step();
    alloc_req = 1; #1;
    check("alloc_pid5", 32'(alloc_pid), 5);
    step();
    ckpt_req = 1; #1;
    check("ck2_ack", 32'(ckpt_ack), 1);
    check("ck2_tag", 32'(ckpt_tag), 2);
    step();

    // Mispredict tag 1 (saved ptr 5) with a same-cycle free and requests.
    br_valid = 1; br_tag = 2'd1; br_mispred = 1;
    free_req = 1; free_pid = 7'h45; alloc_req = 1; ckpt_req = 1; #1;
    check("mp1_chg_en", 32'(fifo_chg_r_en), 1);
    check("mp1_chg_val", 32'(fifo_chg_r_val), 5);
    check("mp1_alloc_grant", 32'(alloc_grant), 0);
    check("mp1_ckpt_ack", 32'(ckpt_ack), 0);
    check("mp1_w_en", 32'(fifo_w_en), 1);
    check("mp1_din", 32'(fifo_din), 32'h45);
    check("mp1_flush_early", 32'(flush), 0);
    step();
    alloc_req = 1; ckpt_req = 1; #1;
    check("fl1_flush", 32'(flush), 1);
    check("fl1_mask", 32'(flush_mask), 32'b0110);
    check("fl1_alloc_grant", 32'(alloc_grant), 0);
    check("fl1_ckpt_ack", 32'(ckpt_ack), 0);
    step();
    check("fl1_flush_end", 32'(flush), 0);
    check("fl1_mask_end", 32'(flush_mask), 0);
    check("r_ptr_restored", 32'(r_ptr), 5);

    for (int i = 1; i < 4; i++) begin
      ckpt_req = 1; #1;
      check("refill_ack", 32'(ckpt_ack), 1);
      check("refill_tag", 32'(ckpt_tag), 32'(i));
      step();
    end
    ckpt_req = 1; br_valid = 1; br_tag = 2'd2; br_mispred = 0; #1;
    check("full_flag", 32'(ckpt_full), 1);
    check("full_ack", 32'(ckpt_ack), 0);
    step();
    ckpt_req = 1; #1;
    check("reuse_full", 32'(ckpt_full), 0);
    check("reuse_ack", 32'(ckpt_ack), 1);
    check("reuse_tag", 32'(ckpt_tag), 2);
    step();

    // Tag 0 kept its pointer across the earlier flush; all others are younger.
    br_valid = 1; br_tag = 2'd0; br_mispred = 1; #1;
    check("mp0_chg_val", 32'(fifo_chg_r_val), 4);
    step();
    check("fl0_mask", 32'(flush_mask), 32'b1111);
    step();

    br_valid = 1; br_tag = 2'd3; br_mispred = 1; #1;
    check("bad_chg_en", 32'(fifo_chg_r_en), 0);
    step();
    check("bad_ckpt_err", 32'(ckpt_err), 1);
    check("bad_flush", 32'(flush), 0);
    ckpt_req = 1; #1;
    check("post_bad_tag", 32'(ckpt_tag), 0);
    check("post_bad_ack", 32'(ckpt_ack), 1);
    step();
    check("ckpt_err_clear", 32'(ckpt_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
